// File: rtl/core_ifq.sv
// core_ifq: instruction queue between fetch and decode.
// Buffers up to DEPTH {pc, instr} pairs, raises if_halt when nearly full,
// and discards everything on a redirect flush. An empty queue presents a NOP
// so decode sees a bubble.
module core_ifq #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [5:0]  OPCODE_NOP = 6'h05
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       flush,
  output logic                       if_halt,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_HALT = LW'(DEPTH - 1);
  localparam logic [31:0]   NOP      = {OPCODE_NOP, 26'(0)};

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic pop;
  logic push_req;
  logic push_ok;
  logic push_drop;

  // Handshake decode; a pop frees a slot so a full queue can still accept.
  always_comb begin
    pop       = out_valid & out_ready;
    push_req  = in_valid & ~flush;
    push_ok   = push_req & ((level < LVL_FULL) | pop);
    push_drop = push_req & ~push_ok;
  end

  // Pointers, occupancy and sticky overflow; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      level <= level + LW'(1);
      else if (!push_ok && pop) level <= level - LW'(1);
      if (push_drop) ovf <= 1'b1;
    end
  end

  // Entry storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // Head presentation and halt request, all from registered state.
  always_comb begin
    out_valid = (level != '0);
    if_halt   = (level >= LVL_HALT);
    out_pc    = '0;
    out_instr = NOP;
    if (out_valid) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_core_ifq.sv
// Directed self-checking bench for core_ifq (DEPTH=4).
module tb_core_ifq;

  localparam logic [31:0] NOP = 32'h1400_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        if_halt;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  level;
  logic        ovf;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  core_ifq #(.DEPTH(4), .OPCODE_NOP(6'h05)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .if_halt   (if_halt),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the rising edge.
  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    rst       = r;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pc"},    out_pc,         32'd0);
    chk({tag, "_instr"}, out_instr,      NOP);
    chk({tag, "_level"}, 32'(level),     32'd0);
    chk({tag, "_halt"},  32'(if_halt),   32'd0);
  endtask

  initial begin
    // Reset then idle
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_empty("reset");
    chk("reset_ovf", 32'(ovf), 32'd0);

    // Streaming with simultaneous push/pop across four pointer wraps
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 32'(i * 4), 1'b1, 1'b0);
      chk($sformatf("stream_pc%0d", i),    out_pc,          32'(i * 4));
      chk($sformatf("stream_instr%0d", i), out_instr,       instr_of(32'(i * 4)));
      chk($sformatf("stream_lvl%0d", i),   32'(level),      32'd1);
      chk($sformatf("stream_halt%0d", i),  32'(if_halt),    32'd0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_empty("stream_end");

    // Fill to full, then overflow
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    chk("fill1_lvl", 32'(level), 32'd1);
    chk("fill1_halt", 32'(if_halt), 32'd0);
    chk("fill1_pc", out_pc, 32'h100);
    step(1'b0, 1'b1, 32'h104, 1'b0, 1'b0);
    chk("fill2_lvl", 32'(level), 32'd2);
    chk("fill2_halt", 32'(if_halt), 32'd0);
    step(1'b0, 1'b1, 32'h108, 1'b0, 1'b0);
    chk("fill3_lvl", 32'(level), 32'd3);
    chk("fill3_halt", 32'(if_halt), 32'd1);
    step(1'b0, 1'b1, 32'h10C, 1'b0, 1'b0);
    chk("fill4_lvl", 32'(level), 32'd4);
    chk("fill4_ovf", 32'(ovf), 32'd0);
    chk("fill4_pc", out_pc, 32'h100);
    step(1'b0, 1'b1, 32'h110, 1'b0, 1'b0);
    chk("ovf_lvl", 32'(level), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_pc", out_pc, 32'h100);

    // Full with simultaneous push and pop
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
    chk("fullpp_lvl", 32'(level), 32'd4);
    chk("fullpp_pc", out_pc, 32'h104);
    chk("fullpp_ovf", 32'(ovf), 32'd1);

    // Drain: 0x104, 0x108, 0x10C, 0x200 in order
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain1_pc", out_pc, 32'h108);
    chk("drain1_lvl", 32'(level), 32'd3);
    chk("drain1_halt", 32'(if_halt), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain2_pc", out_pc, 32'h10C);
    chk("drain2_lvl", 32'(level), 32'd2);
    chk("drain2_halt", 32'(if_halt), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain3_pc", out_pc, 32'h200);
    chk("drain3_instr", out_instr, instr_of(32'h200));
    chk("drain3_lvl", 32'(level), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_empty("drain_end");

    // Flush at level 3 with a concurrent push and pop
    step(1'b0, 1'b1, 32'h2F0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h2F4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h2F8, 1'b0, 1'b0);
    chk("preflush_lvl", 32'(level), 32'd3);
    chk("preflush_halt", 32'(if_halt), 32'd1);
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    chk_empty("flush");
    chk("flush_ovf", 32'(ovf), 32'd1);
    step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
    chk("postflush_lvl", 32'(level), 32'd1);
    chk("postflush_pc", out_pc, 32'h400);
    chk("postflush_instr", out_instr, instr_of(32'h400));
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_empty("postflush_drain");

    // Reset mid-operation with a concurrent push
    step(1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h504, 1'b0, 1'b0);
    chk("prerst_lvl", 32'(level), 32'd2);
    chk("prerst_ovf", 32'(ovf), 32'd1);
    step(1'b1, 1'b1, 32'h600, 1'b1, 1'b0);
    chk_empty("midrst");
    chk("midrst_ovf", 32'(ovf), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_empty("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
